// File: rtl/ofifo.sv
// Output-side buffer for the systolic array: each column pushes partial sums on
// its own strobe, and the consumer pops one aligned row across all columns per cycle.
module ofifo #(
   parameter int col   = 8,
   parameter int bw    = 16,
   parameter int depth = 64   // power of two, at least 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [col*bw-1:0] in,
   input  logic [col-1:0]    wr,
   input  logic              rd,
   output logic [col*bw-1:0] out,
   output logic              o_valid,
   output logic              o_full,
   output logic              o_ready,
   output logic              o_out_valid
);

   localparam int aw = $clog2(depth);

   // The extra MSB on each pointer is the wrap bit that separates full from empty.
   logic [aw:0]        rp;
   logic [col-1:0]     empty;
   logic [col-1:0]     full;
   logic [col*bw-1:0]  rd_row;
   logic               pop;

   for (genvar i = 0; i < col; i++) begin : g_lane
      logic [bw-1:0] mem [depth];
      logic [aw:0]   wp;
      logic          push;

      assign empty[i] = (wp == rp);
      assign full[i]  = (wp[aw-1:0] == rp[aw-1:0]) && (wp[aw] != rp[aw]);
      assign push     = wr[i] && !full[i];

      // NOTE: sequential state is updated with non-blocking assignments only.
      always_ff @(posedge clk) begin
         if (reset)
            wp <= '0;
         else if (push)
            wp <= wp + (aw+1)'(1);
      end

      // NOTE: storage has no reset; emptiness is carried entirely by the pointers.
      always_ff @(posedge clk) begin
         if (push && !reset)
            mem[wp[aw-1:0]] <= in[bw*i +: bw];
      end

      assign rd_row[bw*i +: bw] = mem[rp[aw-1:0]];
   end

   // Flags come from pre-edge pointers, so same-edge write/pop never see each other.
   assign o_valid = &(~empty);
   assign o_full  = |full;
   assign o_ready = ~o_full;
   assign pop     = rd && o_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         rp          <= '0;
         out         <= '0;
         o_out_valid <= 1'b0;
      end else begin
         o_out_valid <= pop;
         if (pop) begin
            out <= rd_row;
            rp  <= rp + (aw+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_ofifo.sv
// Directed self-checking bench for ofifo: reset state, skewed fill, full/drop,
// read on empty, concurrent streaming with pointer wrap, and mid-stream reset.
module tb_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic [COL*BW-1:0]  din;
   logic [COL-1:0]     wr;
   logic               rd;
   logic [COL*BW-1:0]  dout;
   logic               o_valid, o_full, o_ready, o_out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   ofifo #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (din),
      .wr         (wr),
      .rd         (rd),
      .out        (dout),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_ready    (o_ready),
      .o_out_valid(o_out_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [COL*BW-1:0] obs, input logic [COL*BW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [COL*BW-1:0] row_all(input logic [BW-1:0] v);
      logic [COL*BW-1:0] r;
      for (int i = 0; i < COL; i++) r[BW*i +: BW] = v;
      return r;
   endfunction

   function automatic logic [COL*BW-1:0] row_seq(input logic [BW-1:0] base);
      logic [COL*BW-1:0] r;
      for (int i = 0; i < COL; i++) r[BW*i +: BW] = base + BW'(i);
      return r;
   endfunction

   initial begin
      logic [COL*BW-1:0] exp_row;

      reset = 1'b1; din = '0; wr = '0; rd = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      check("rst_valid", o_valid, 0);
      check("rst_full", o_full, 0);
      check("rst_ready", o_ready, 1);
      check("rst_out", dout, 0);
      check("rst_out_valid", o_out_valid, 0);

      // Skewed fill: lane c writes on cycle c.
      din = row_seq(16'h0100);
      for (int c = 0; c < COL; c++) begin
         wr = COL'(1) << c;
         tick();
         check($sformatf("skew_valid_%0d", c), o_valid, (c == COL-1) ? 1 : 0);
      end
      wr = '0; rd = 1'b1;
      tick();
      rd = 1'b0;
      check("skew_out", dout, row_seq(16'h0100));
      check("skew_out_valid", o_out_valid, 1);
      check("skew_valid_after", o_valid, 0);
      tick();
      check("skew_out_valid_drop", o_out_valid, 0);
      check("skew_out_hold", dout, row_seq(16'h0100));

      // Fill lane 3 alone to capacity.
      din = '0; wr = 8'h08;
      for (int k = 0; k < DEPTH; k++) begin
         din[BW*3 +: BW] = 16'h3000 + BW'(k);
         tick();
         if (k == DEPTH-2) check("fill_not_full_63", o_full, 0);
      end
      check("fill_full", o_full, 1);
      check("fill_ready", o_ready, 0);
      check("fill_valid", o_valid, 0);
      din[BW*3 +: BW] = 16'hDEAD;
      tick();
      check("drop_full", o_full, 1);
      check("drop_valid", o_valid, 0);

      din = row_seq(16'h0A00); wr = 8'hF7;
      tick();
      check("others_valid", o_valid, 1);
      check("others_full", o_full, 1);
      // Pop while lane 3 is full and also strobed: write dropped, pop proceeds.
      din[BW*3 +: BW] = 16'hDEAD; wr = 8'h08; rd = 1'b1;
      tick();
      wr = '0; rd = 1'b0;
      exp_row = row_seq(16'h0A00);
      exp_row[BW*3 +: BW] = 16'h3000;
      check("full_pop_out", dout, exp_row);
      check("full_pop_out_valid", o_out_valid, 1);
      check("full_pop_full_clear", o_full, 0);
      check("full_pop_ready", o_ready, 1);
      check("full_pop_valid", o_valid, 0);

      // Read on empty after reset.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("empty_rd_out_%0d", c), dout, 0);
         check($sformatf("empty_rd_ov_%0d", c), o_out_valid, 0);
      end

      // Streaming: first row lands while rd is ignored, then push+pop every cycle.
      wr = '1; din = row_all(16'd0);
      tick();
      check("stream_first_ov", o_out_valid, 0);
      check("stream_first_valid", o_valid, 1);
      for (int k = 1; k < 200; k++) begin
         din = row_all(BW'(k));
         tick();
         check($sformatf("stream_out_%0d", k-1), dout, row_all(BW'(k-1)));
         check($sformatf("stream_ov_%0d", k-1), o_out_valid, 1);
         check($sformatf("stream_full_%0d", k-1), o_full, 0);
      end
      wr = '0;
      tick();
      rd = 1'b0;
      check("stream_out_199", dout, row_all(16'd199));
      check("stream_drained", o_valid, 0);

      // Mid-stream reset with 10 rows buffered; strobes during reset are ignored.
      wr = '1;
      for (int j = 0; j < 10; j++) begin
         din = row_all(16'h0500 + BW'(j));
         tick();
      end
      check("mid_valid_before", o_valid, 1);
      reset = 1'b1; rd = 1'b1; din = row_all(16'hBAD0);
      tick();
      reset = 1'b0; wr = '0; rd = 1'b0;
      check("mid_valid", o_valid, 0);
      check("mid_out", dout, 0);
      check("mid_out_valid", o_out_valid, 0);
      check("mid_full", o_full, 0);
      wr = '1; din = row_all(16'h0777);
      tick();
      wr = '0; rd = 1'b1;
      tick();
      rd = 1'b0;
      check("mid_new_out", dout, row_all(16'h0777));
      check("mid_new_ov", o_out_valid, 1);
      check("mid_new_empty", o_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output-side buffer for the systolic array.
- Each of `col` PE columns pushes partial sums independently and at staggered times, using its own write strobe.
- The consumer (SFU or output SRAM writer) pops one full row at a time, taking all columns in a single cycle.
- This is the column-skewed write / aligned read counterpart of the row-skewed input buffer.

Parameters:
- col, 8, number of array columns (lanes).
- bw, 16, psum width per lane in bits.
- depth, 64, entries per lane; must be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  col*bw  lane i data in bits [bw*(i+1)-1 : bw*i].
- wr  input  col  per-lane write strobe; bit i pushes lane i.
- rd  input  1  pop request for one aligned row across all lanes.
- out  output  col*bw  registered row data; lane i in bits [bw*(i+1)-1 : bw*i].
- o_valid  output  1  every lane holds at least 1 entry, so a row is poppable.
- o_full  output  1  at least one lane is full.
- o_ready  output  1  equals ~o_full.
- o_out_valid  output  1  pulses high for one cycle when out was updated by a pop on the previous edge.

Behaviour:
- One clock and a synchronous, active-high reset. Reset is sampled only on the rising edge of clk.
- Storage:
  - Per-lane array of depth x bw.
  - Per-lane write pointer wp[i] of log2(depth)+1 bits.
  - One shared read pointer rp of log2(depth)+1 bits. All lanes advance together.
  - The MSB of each pointer is the wrap bit.
- Lane status, combinational from current pointers:
  - empty[i] = (wp[i] == rp).
  - full[i] = (low bits equal) AND (wrap bits differ).
- Flags:
  - o_valid = AND of ~empty[i].
  - o_full = OR of full[i].
  - o_ready = ~o_full.
- Reset (while reset=1):
  - all wp = 0, rp = 0, out = 0, o_out_valid = 0.
  - Therefore o_valid=0, o_full=0, o_ready=1.
  - Memory contents are not cleared.
  - wr and rd are ignored during reset.
  - A reset asserted mid-stream discards all buffered data on that edge.
- Write, per lane and independent across lanes:
  - On an edge with wr[i]=1 and full[i]=0: mem_i[wp[i]] <= lane i of in, and wp[i] increments modulo 2*depth.
  - wr[i] with full[i]=1 is dropped: no pointer change, no overwrite.
- Read:
  - On an edge with rd=1 and o_valid=1: out <= {mem_{col-1}[rp], ..., mem_0[rp]}, rp increments, and o_out_valid <= 1.
  - rd with o_valid=0 is ignored: out holds, o_out_valid <= 0.
  - When no pop occurs, out holds its last value and o_out_valid <= 0.
- Latency:
  - Data written on edge N is visible to a pop on edge N+1 at the earliest, once every lane is non-empty.
  - out is valid from edge N+1 after rd is sampled at edge N.
- Simultaneous events: all flags are evaluated on pre-edge state.
  - Lane full, with wr[i] and a valid pop on the same edge: the write is still dropped; the pop proceeds.
  - Lane empty, with wr[i] and rd on the same edge: o_valid=0, so rd is ignored; the write lands.
  - Non-full, non-empty lane with a simultaneous write and pop: both occur; lane occupancy is unchanged.
- Wrap-around:
  - Pointers roll from 2*depth-1 to 0.
  - Data order is preserved across the wrap; there is no bubble.
- Occupancy: lanes may differ by up to depth entries. o_valid tracks the minimum occupancy across lanes.

Test Plan:
- Reset, then idle 3 cycles -> o_valid=0, o_full=0, o_ready=1, out=0, o_out_valid=0.
- Skewed fill:
  - Stimulus: lane i writes value 16'h0100+i starting at cycle i, each lane writing once.
  - Expected: o_valid stays 0 until the edge after lane 7 writes, then rises to 1.
  - Then: rd=1 for one cycle -> next cycle out lanes 0..7 = 0100..0107, o_out_valid=1; afterwards o_valid=0.
- Full and drop:
  - Stimulus: write 64 entries into lane 3 only.
  - Expected: o_full=1, o_ready=0. A 65th write of 16'hDEAD is dropped; o_valid remains 0.
  - Then: fill the other lanes with 1 entry each and pop once -> lane 3 out = its first entry; o_full drops to 0.
- Read on empty:
  - Stimulus: rd=1 for 5 cycles with no data.
  - Expected: out, rp and o_out_valid are unchanged (0).
- Concurrent push/pop and wrap:
  - Stimulus: stream 200 rows where all lanes write a count k and rd=1 every cycle after the first row.
  - Expected: out sequence is k=0..199 in order with no loss, and o_full is never set.
- Reset mid-stream:
  - Stimulus: with 10 rows buffered, assert reset for 1 cycle.
  - Expected: o_valid=0, out=0. A subsequent row write followed by a pop returns only the new data.
